// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared constants for the nibble-serial adder
// Purpose: FSM state encodings, datapath slice width and the signed-overflow
//   rule, shared by every file of the serial_add_ctrl block.
// Ports: none (package).
package serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic signed_ofl(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rca_4b.sv
// rtl/rca_4b.sv - 4-bit ripple-carry adder slice
// Purpose: combinational 4-bit add built from full-adder equations.
// Ports:
//   a, b  in  [3:0]  addends
//   cin   in         carry-in
//   sum   out [3:0]  sum bits
//   cout  out        carry-out of bit 3
module rca_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial add/subtract controller
// Purpose: computes A+B+C_in or A-B one nibble per cycle through a single
//   4-bit ripple-carry adder, LS nibble first, with fixed latency.
// Ports:
//   clk    in           clock, rising edge
//   rst    in           synchronous active-high reset
//   start  in           begin an operation (honoured only in IDLE)
//   sub    in           0: A+B+C_in, 1: A-B
//   A, B   in  [N-1:0]  operands, sampled with start
//   C_in   in           carry-in for add, sampled with start
//   S      out [N-1:0]  registered result
//   C_out  out          final carry (sub: 1 = no borrow)
//   Ofl    out          signed overflow
//   busy   out          operation in progress
//   done   out          one-cycle pulse when S/C_out/Ofl are valid
module serial_add_ctrl #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic [N-1:0] S,
  output logic         C_out,
  output logic         Ofl,
  output logic         busy,
  output logic         done
);

  import serial_add_ctrl_pkg::*;

  localparam int NUM_NIB = N / NIB_W;
  localparam int CNT_W   = $clog2(NUM_NIB);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

  state_t           state;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;

  rca_4b u_rca (
    .a    (a_reg[{cnt, 2'b00} +: NIB_W]),
    .b    (b_reg[{cnt, 2'b00} +: NIB_W]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // busy/done are registered from the state of the previous cycle, which
  // places done one cycle after the FSM enters DONE, alongside C_out/Ofl.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      C_out <= 1'b0;
      Ofl   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state != ST_IDLE);
      done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= A;
            // Subtract as A + ~B + 1.
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : C_in;
            cnt   <= '0;
            S     <= '0;
            C_out <= 1'b0;
            Ofl   <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          S[{cnt, 2'b00} +: NIB_W] <= nib_sum;
          carry <= nib_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_NIB) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          C_out <= carry;
          Ofl   <= signed_ofl(a_reg[N-1], b_reg[N-1], S[N-1]);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic [15:0] S;
  logic        C_out;
  logic        Ofl;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.N(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .S     (S),
    .C_out (C_out),
    .Ofl   (Ofl),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept at edge 0, done expected only after edge 5; optional extra start
  // pulse sampled at edge poke_k must be ignored. Inputs are scrambled after
  // accept to show the in-flight result is isolated from them.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s_sub, input logic cin, input logic [15:0] exp_s,
                        input logic exp_c, input logic exp_o, input int poke_k);
    A = a; B = b; sub = s_sub; C_in = cin; start = 1'b1;
    tick();
    start = 1'b0; A = ~a; B = a ^ b ^ 16'h5A5A; sub = ~s_sub; C_in = ~cin;
    for (int k = 1; k <= 5; k++) begin
      if (k == poke_k) begin
        start = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
      end
      tick();
      start = 1'b0;
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " done"}, 32'(done), (k == 5) ? 32'd1 : 32'd0);
    end
    check({tag, " S"}, 32'(S), 32'(exp_s));
    check({tag, " C_out"}, 32'(C_out), 32'(exp_c));
    check({tag, " Ofl"}, 32'(Ofl), 32'(exp_o));
    for (int k = 6; k <= 8; k++) begin
      tick();
      check({tag, " idle done"}, 32'(done), 32'd0);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " hold S"}, 32'(S), 32'(exp_s));
      check({tag, " hold C_out"}, 32'(C_out), 32'(exp_c));
      check({tag, " hold Ofl"}, 32'(Ofl), 32'(exp_o));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0; C_in = 1'b0;
    tick();
    start = 1'b1; A = 16'h1111; B = 16'h2222;
    tick();
    start = 1'b0;
    check("reset S", 32'(S), 32'h0);
    check("reset C_out", 32'(C_out), 32'd0);
    check("reset Ofl", 32'(Ofl), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    run_op("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ofl", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("add_cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ofl", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("ignore_start", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 2);

    // Reset sampled at edge 3 of an operation aborts it.
    A = 16'h1234; B = 16'h0FFF; sub = 1'b0; C_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort S", 32'(S), 32'h0);
    check("abort C_out", 32'(C_out), 32'd0);
    check("abort Ofl", 32'(Ofl), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    run_op("after_abort", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // start held high: back-to-back operations, done every 6 cycles.
    A = 16'h0010; B = 16'h0020; sub = 1'b0; C_in = 1'b0; start = 1'b1;
    tick();
    A = 16'h0100; B = 16'h0200;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("b2b done", 32'(done), (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 5) check("b2b S first", 32'(S), 32'h0030);
      if (k == 11) check("b2b S second", 32'(S), 32'h0300);
    end
    start = 1'b0;
    for (int k = 12; k <= 14; k++) begin
      tick();
      check("b2b tail done", 32'(done), 32'd0);
      check("b2b tail busy", 32'(busy), 32'd0);
      check("b2b tail S", 32'(S), 32'h0300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
